// File: rtl/fir_bank_pkg.sv
// Shared constants, FSM encoding and output rounding helper for the FIR bank.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fir_bank_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int GAIN_W    = 16;
    localparam int GAIN_FRAC = 14;
    localparam int ACC_W     = 36;
    localparam int MAX_BANDS = 16;
    localparam int IDX_W     = $clog2(MAX_BANDS);

    localparam logic [GAIN_W-1:0] GAIN_UNITY = 16'h4000;

    // Half an output LSB in accumulator units, used for round-half-up.
    localparam logic signed [ACC_W-1:0] ROUND_HALF = 36'sd8192;
    localparam logic signed [ACC_W-1:0] SAT_MAX    = 36'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN    = -36'sd32768;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    typedef struct packed {
        logic                clip;
        logic [SAMPLE_W-1:0] val;
    } rs_t;

    // Q3.29 accumulator -> Q1.15 sample: round half up, then clamp.
    function automatic rs_t round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shf;
        rs_t                     r;
        shf = (acc + ROUND_HALF) >>> GAIN_FRAC;
        if (shf > SAT_MAX) begin
            r.clip = 1'b1;
            r.val  = 16'h7FFF;
        end else if (shf < SAT_MIN) begin
            r.clip = 1'b1;
            r.val  = 16'h8000;
        end else begin
            r.clip = 1'b0;
            r.val  = shf[SAMPLE_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_gain_regs.sv
// Shadow/active per-band gain register file with one write port and one indexed read port.
// Latency: writes land in shadow at the next edge; copy_en loads active from shadow (incl. a same-edge write).
// Backpressure: none; writes to addresses >= NBANDS are dropped.
// Ports: clock/reset, wr_en/wr_addr/wr_data (shadow write), copy_en (shadow->active), rd_idx -> rd_gain (active).
module fir_gain_regs
    import fir_bank_pkg::*;
#(
    parameter int NBANDS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [GAIN_W-1:0] wr_data,
    input  logic              copy_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [GAIN_W-1:0] rd_gain
);

    logic [GAIN_W-1:0] shadow_q [NBANDS];
    logic [GAIN_W-1:0] shadow_d [NBANDS];
    logic [GAIN_W-1:0] active_q [NBANDS];

    // Address match per entry; addresses with no matching entry simply hit nothing.
    always_comb begin
        for (int k = 0; k < NBANDS; k++) begin
            shadow_d[k] = shadow_q[k];
            if (wr_en && (wr_addr == IDX_W'(k))) begin
                shadow_d[k] = wr_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NBANDS; k++) begin
                shadow_q[k] <= GAIN_UNITY;
                active_q[k] <= GAIN_UNITY;
            end
        end else begin
            for (int k = 0; k < NBANDS; k++) begin
                shadow_q[k] <= shadow_d[k];
                // Copy from shadow_d so a write on the accept edge is captured.
                if (copy_en) begin
                    active_q[k] <= shadow_d[k];
                end
            end
        end
    end

    always_comb begin
        rd_gain = '0;
        for (int k = 0; k < NBANDS; k++) begin
            if (rd_idx == IDX_W'(k)) begin
                rd_gain = active_q[k];
            end
        end
    end

endmodule

// File: rtl/fir_band_mixer.sv
// Weights each band sample by a programmable Q2.14 gain, sums, rounds and saturates to one Q1.15 output.
// Latency: NBANDS+1 cycles from band_valid to the one-cycle mix_valid pulse.
// Backpressure: none; band_valid outside IDLE is dropped and flagged in sticky overrun.
// Ports: band_data/band_valid (frame in), gain_wr_* (gain write), mix_out/mix_valid (result), busy/overrun/clip (status).
module fir_band_mixer
    import fir_bank_pkg::*;
#(
    parameter int NBANDS = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [SAMPLE_W*NBANDS-1:0]   band_data,
    input  logic                         band_valid,
    input  logic                         gain_wr_en,
    input  logic [IDX_W-1:0]             gain_wr_addr,
    input  logic [GAIN_W-1:0]            gain_wr_data,
    output logic [SAMPLE_W-1:0]          mix_out,
    output logic                         mix_valid,
    output logic                         busy,
    output logic                         overrun,
    output logic                         clip
);

    state_e                   state_q;
    logic [IDX_W-1:0]         idx_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [SAMPLE_W-1:0]      snap_q [NBANDS];
    logic [SAMPLE_W-1:0]      mix_out_q;
    logic                     mix_valid_q;
    logic                     busy_q;
    logic                     overrun_q;
    logic                     clip_q;

    logic                     frame_accept;
    logic [GAIN_W-1:0]        gain_cur;
    logic [SAMPLE_W-1:0]      snap_cur;
    logic signed [31:0]       prod;
    logic signed [ACC_W-1:0]  prod_ext;
    rs_t                      rs;

    assign frame_accept = (state_q == IDLE) && band_valid;

    fir_gain_regs #(
        .NBANDS (NBANDS)
    ) u_gain_regs (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (gain_wr_en),
        .wr_addr (gain_wr_addr),
        .wr_data (gain_wr_data),
        .copy_en (frame_accept),
        .rd_idx  (idx_q),
        .rd_gain (gain_cur)
    );

    always_comb begin
        snap_cur = '0;
        for (int k = 0; k < NBANDS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                snap_cur = snap_q[k];
            end
        end
    end

    // Single-cycle combinational multiply; Q1.15 x Q2.14 = Q3.29.
    assign prod     = $signed(snap_cur) * $signed(gain_cur);
    assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
    assign rs       = round_sat(acc_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            clip_q      <= 1'b0;
            for (int k = 0; k < NBANDS; k++) begin
                snap_q[k] <= '0;
            end
        end else begin
            mix_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (band_valid) begin
                        for (int k = 0; k < NBANDS; k++) begin
                            snap_q[k] <= band_data[SAMPLE_W*k +: SAMPLE_W];
                        end
                        acc_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    if (band_valid) begin
                        overrun_q <= 1'b1;
                    end
                    acc_q <= acc_q + prod_ext;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IDX_W'(NBANDS-1)) begin
                        state_q <= OUT;
                    end
                end
                OUT: begin
                    if (band_valid) begin
                        overrun_q <= 1'b1;
                    end
                    mix_out_q   <= rs.val;
                    mix_valid_q <= 1'b1;
                    clip_q      <= clip_q | rs.clip;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign clip      = clip_q;

endmodule

// File: tb/tb_fir_band_mixer.sv
// Directed + randomized bench for fir_band_mixer against a plain-arithmetic mixing model.
// Latency: checks mix_valid exactly NBANDS+1 cycles after band_valid.
// Backpressure: exercises band_valid during MAC/OUT and gain writes during a frame.
module tb_fir_band_mixer;

    localparam int NB = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [16*NB-1:0]  band_data;
    logic              band_valid;
    logic              gain_wr_en;
    logic [3:0]        gain_wr_addr;
    logic [15:0]       gain_wr_data;
    logic [15:0]       mix_out;
    logic              mix_valid;
    logic              busy;
    logic              overrun;
    logic              clip;

    int errors = 0;
    int checks = 0;

    // Reference state: gain banks, sticky flags, last output.
    int          sh [NB];
    int          ag [NB];
    int          bands [NB];
    bit          ovr_m;
    bit          clip_m;
    logic [15:0] last_out;

    fir_band_mixer #(.NBANDS(NB)) dut (
        .clock        (clock),
        .reset        (reset),
        .band_data    (band_data),
        .band_valid   (band_valid),
        .gain_wr_en   (gain_wr_en),
        .gain_wr_addr (gain_wr_addr),
        .gain_wr_data (gain_wr_data),
        .mix_out      (mix_out),
        .mix_valid    (mix_valid),
        .busy         (busy),
        .overrun      (overrun),
        .clip         (clip)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NB; k++) begin
            sh[k] = 16384;
            ag[k] = 16384;
        end
        ovr_m    = 1'b0;
        clip_m   = 1'b0;
        last_out = 16'h0000;
    endfunction

    // Sum of band*gain in real units (scaled 2^29), round half up to 2^-15, clamp to 16 bits.
    function automatic void model_mix(output logic [15:0] v, output bit c);
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < NB; k++) begin
            acc += longint'(bands[k]) * longint'(ag[k]);
        end
        r = (acc + 64'sd8192) >>> 14;
        c = 1'b0;
        if (r > 32767) begin
            r = 32767;
            c = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            c = 1'b1;
        end
        v = 16'(r);
    endfunction

    task automatic wr_gain(input logic [3:0] a, input logic [15:0] d);
        @(negedge clock);
        gain_wr_en   = 1'b1;
        gain_wr_addr = a;
        gain_wr_data = d;
        if (int'(a) < NB) sh[int'(a)] = int'($signed(d));
        @(negedge clock);
        gain_wr_en = 1'b0;
    endtask

    // act: 0 none, 1 gain write during frame, 2 band_valid during frame (at negedge k).
    // cw: gain write on the same edge the frame is accepted.
    task automatic run_frame(input string tag, input int act, input int act_k,
                             input logic [3:0] a_addr, input logic [15:0] a_data,
                             input bit cw, input logic [3:0] cw_addr, input logic [15:0] cw_data);
        logic [15:0] exp_v;
        bit          exp_c;
        @(negedge clock);
        for (int k = 0; k < NB; k++) band_data[16*k +: 16] = 16'(bands[k]);
        band_valid = 1'b1;
        if (cw) begin
            gain_wr_en   = 1'b1;
            gain_wr_addr = cw_addr;
            gain_wr_data = cw_data;
            if (int'(cw_addr) < NB) sh[int'(cw_addr)] = int'($signed(cw_data));
        end
        ag = sh;
        model_mix(exp_v, exp_c);
        clip_m = clip_m | exp_c;
        @(posedge clock);
        for (int k = 0; k <= NB + 1; k++) begin
            @(negedge clock);
            band_valid = 1'b0;
            gain_wr_en = 1'b0;
            chk({tag, "_busy"}, 32'(busy), 32'(k <= NB));
            chk({tag, "_vld"}, 32'(mix_valid), 32'(k == NB + 1));
            if (k == NB + 1) begin
                chk({tag, "_out"}, 32'(mix_out), 32'(exp_v));
                chk({tag, "_clip"}, 32'(clip), 32'(clip_m));
                chk({tag, "_ovr"}, 32'(overrun), 32'(ovr_m));
            end else if (k < NB + 1) begin
                chk({tag, "_hold"}, 32'(mix_out), 32'(last_out));
            end
            if (k == act_k && k <= NB) begin
                if (act == 1) begin
                    gain_wr_en   = 1'b1;
                    gain_wr_addr = a_addr;
                    gain_wr_data = a_data;
                    if (int'(a_addr) < NB) sh[int'(a_addr)] = int'($signed(a_data));
                end else if (act == 2) begin
                    band_valid = 1'b1;
                    band_data  = {NB{16'($urandom)}};
                    ovr_m      = 1'b1;
                end
            end
        end
        last_out = exp_v;
        @(negedge clock);
        chk({tag, "_vld_fall"}, 32'(mix_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] d;
        reset        = 1'b1;
        band_data    = '0;
        band_valid   = 1'b0;
        gain_wr_en   = 1'b0;
        gain_wr_addr = '0;
        gain_wr_data = '0;
        model_reset();

        // Reset values
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_out", 32'(mix_out), 32'd0);
        chk("rst_vld", 32'(mix_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_clip", 32'(clip), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Unity mix: gains left at reset value
        bands = '{1000, 2000, -500, 0};
        run_frame("unity", 0, 0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        chk("unity_val", 32'(mix_out), 32'(16'd2500));

        // Rounding
        wr_gain(4'd0, 16'h2000);
        wr_gain(4'd1, 16'h0000);
        wr_gain(4'd2, 16'h0000);
        wr_gain(4'd3, 16'h0000);
        bands = '{3, 1234, -999, 32767};
        run_frame("round_pos", 0, 0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        chk("round_pos_val", 32'(mix_out), 32'(16'd2));
        bands = '{-3, -7, 5, -32768};
        run_frame("round_neg", 0, 0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        chk("round_neg_val", 32'(mix_out), 32'(16'hFFFF));

        // Saturation
        for (int k = 0; k < NB; k++) wr_gain(4'(k), 16'h7FFF);
        bands = '{32767, 32767, 32767, 32767};
        run_frame("sat_pos", 0, 0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        chk("sat_pos_val", 32'(mix_out), 32'(16'h7FFF));
        chk("sat_pos_clip", 32'(clip), 32'd1);
        bands = '{-32768, -32768, -32768, -32768};
        run_frame("sat_neg", 0, 0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        chk("sat_neg_val", 32'(mix_out), 32'(16'h8000));

        // Gain shadowing: write gain1=0 mid-MAC, then next frame uses it
        for (int k = 0; k < NB; k++) wr_gain(4'(k), 16'h4000);
        bands = '{100, 200, 300, 400};
        run_frame("shadow_cur", 1, 1, 4'd1, 16'h0000, 1'b0, 4'd0, 16'd0);
        chk("shadow_cur_val", 32'(mix_out), 32'(16'd1000));
        run_frame("shadow_next", 0, 0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        chk("shadow_next_val", 32'(mix_out), 32'(16'd800));

        // Overrun during MAC; also a write to a nonexistent band, ignored
        wr_gain(4'd9, 16'h1234);
        run_frame("overrun", 2, 2, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        chk("overrun_val", 32'(mix_out), 32'(16'd800));
        chk("overrun_flag", 32'(overrun), 32'd1);

        // Same-edge write is part of the copy
        run_frame("cw_copy", 0, 0, 4'd0, 16'd0, 1'b1, 4'd3, 16'h2000);
        chk("cw_copy_val", 32'(mix_out), 32'(16'd600));

        // Reset mid-frame at E2
        @(negedge clock);
        for (int k = 0; k < NB; k++) band_data[16*k +: 16] = 16'(16'd1111);
        band_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        band_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_out", 32'(mix_out), 32'd0);
        chk("midrst_ovr", 32'(overrun), 32'd0);
        chk("midrst_clip", 32'(clip), 32'd0);
        for (int k = 0; k < NB + 3; k++) begin
            @(negedge clock);
            chk("midrst_no_vld", 32'(mix_valid), 32'd0);
        end
        bands = '{-1000, 4000, 250, -250};
        run_frame("after_rst", 0, 0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        chk("after_rst_val", 32'(mix_out), 32'(16'd3000));

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) begin
                if ($urandom_range(0, 1) == 1) d = 16'($urandom);
                else d = 16'($urandom_range(0, 32768) - 16384);
                wr_gain(4'($urandom_range(0, 7)), d);
            end
            for (int k = 0; k < NB; k++) bands[k] = int'($signed(16'($urandom)));
            d = 16'($urandom);
            run_frame("rand", int'($urandom_range(0, 2)), int'($urandom_range(0, NB)),
                      4'($urandom_range(0, 5)), d,
                      1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_band_mixer.md
# fir_band_mixer

Downstream stage of the FIR filter bank. Takes the 16-bit outputs of all band filters once per input sample and multiplies each band by a programmable signed gain. It accumulates the weighted bands, then rounds and saturates the sum to a single 16-bit output with a one-cycle valid strobe. The bank controller drives it, pulsing `band_valid` once every filter has loaded its output register.

## Interface
- `NBANDS`, default 4: number of bands; legal range 1..16.
- `clock`  in  1: system clock; all logic is rising-edge.
- `reset`  in  1: reset, synchronous, active-high.
- `band_data`  in  16*NBANDS: band outputs, signed Q1.15; band k occupies bits [16k+15:16k].
- `band_valid`  in  1: one-cycle pulse; all bands hold a new sample.
- `gain_wr_en`  in  1: gain write strobe.
- `gain_wr_addr`  in  4: band index for the gain write.
- `gain_wr_data`  in  16: gain, signed Q2.14; 0x4000 is unity.
- `mix_out`  out  16: mixed sample, signed Q1.15; resets to 0; holds its value between frames.
- `mix_valid`  out  1: one-cycle pulse when `mix_out` updates; resets to 0.
- `busy`  out  1: high when state is not IDLE; resets to 0.
- `overrun`  out  1: sticky; set when `band_valid` arrives outside IDLE; resets to 0.
- `clip`  out  1: sticky; set when an output saturates; resets to 0.

## Operation
- **Gain registers**
  - Two banks: shadow (the write target) and active (used by the MAC).
  - Both banks reset to 0x4000 in every entry.
  - A write is accepted on any cycle when `gain_wr_en` is high and `gain_wr_addr < NBANDS`. Other addresses are ignored.
  - Active is copied from shadow only when a frame is accepted. A write on that same edge is included in the copy.
- **State machine**: IDLE → MAC → OUT → IDLE.
  - IDLE: when `band_valid` is high, snapshot `band_data`, copy shadow gains to active, clear the accumulator, set `idx` to 0, and go to MAC.
  - MAC: add `snap[idx] * gain[idx]` to the accumulator and increment `idx`. After the edge that processes `idx = NBANDS-1`, go to OUT.
  - OUT: register the rounded and saturated result into `mix_out`, set `mix_valid` to 1, and go to IDLE.
- **Arithmetic**
  - Product: 16x16 signed, 32-bit, Q3.29.
  - Accumulator: 36-bit signed, which cannot overflow for NBANDS ≤ 16.
  - Rounding: `acc + 2^13`, then arithmetic shift right by 14. This is round-half-up.
  - Saturation: the shifted value is clamped to [-32768, 32767]. When clamped, set `clip`.
- **Boundary conditions**
  - `band_valid` in MAC or OUT: the frame is ignored, `overrun` is set, and the computation in progress is unaffected.
  - `band_data` may change freely after it has been snapshotted.
  - `reset` at any time returns the block to IDLE and restores every output, both gain banks and both sticky flags to reset values. The frame in progress is discarded with no `mix_valid`.
  - With NBANDS = 1, MAC lasts exactly one cycle.

## Timing
- E0 is the edge at which `band_valid` is sampled in IDLE.
- Edges E1..E_NBANDS are the MAC accumulations.
- At edge E_(NBANDS+1), `mix_out` updates and `mix_valid` rises. It falls at the next edge.
- Latency from `band_valid` to `mix_valid` is NBANDS+1 cycles. `busy` is high from E0 to E_(NBANDS+1).
- Minimum `band_valid` spacing is NBANDS+2 cycles. This is far below the filter frame period of about 70 cycles.
- The multiply is combinational inside the MAC cycle; no multiplier pipeline is used.

## Structure
- Shared package `fir_bank_pkg` holds the constants:
  - `SAMPLE_W` = 16, `GAIN_W` = 16, `GAIN_FRAC` = 14;
  - `GAIN_UNITY` = 16'h4000, `ACC_W` = 36, `MAX_BANDS` = 16.
- The package also holds the state encodings IDLE, MAC and OUT.
- One sub-module, `fir_gain_regs`, contains the shadow/active gain register file, its write port, the copy strobe and the indexed read port.
- The top level holds the snapshot registers, the FSM, the MAC, the rounding and saturation, and the flags.

## Test plan
- **Reset values:** hold `reset` high for 3 cycles → all outputs are 0; every gain reads back as unity (0x4000).
- **Unity mix:** NBANDS = 4, bands {1000, 2000, -500, 0} at unity gain, `band_valid` at E0 → `mix_out` = 2500 and `mix_valid` high for 1 cycle, starting at E5.
- **Rounding:** gain0 = 0x2000, other gains 0. Band0 = 3 → output 2. Band0 = -3 → output -1.
- **Saturation:** all gains 0x7FFF, all bands 32767 → output 32767 and `clip` = 1. All bands -32768 → output -32768.
- **Gain shadowing and overrun:**
  - Write gain1 = 0 during MAC → the current frame still uses the old gain1; the next frame uses 0.
  - `band_valid` during MAC → `overrun` = 1 and the current result is unchanged.
- **Reset mid-frame:** assert `reset` at E2 → no `mix_valid`, `busy` = 0, and the next frame after reset computes correctly at unity gain.
